// File: rtl/lc4_muldiv_seq.sv
// Iterative LC4 MUL/DIV/MOD unit: one shift-add or restoring-divide step per cycle.
// Holds the pipeline through o_stall until the single-cycle o_done pulse.
module lc4_muldiv_seq #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [15:0]          i_insn,
    input  logic [WORD_SIZE-1:0] i_r1data,
    input  logic [WORD_SIZE-1:0] i_r2data,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WORD_SIZE-1:0] o_result
);
    localparam int CW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_SIZE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_MOD  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           op_q, op_d, op_dec;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] a_q, a_d;       // multiplicand, or dividend shifting into quotient
    logic [WORD_SIZE-1:0] b_q, b_d;       // multiplier, or divisor
    logic [WORD_SIZE-1:0] acc_q, acc_d;   // product accumulator, or partial remainder
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [WORD_SIZE-1:0] mul_sum;
    logic [WORD_SIZE:0]   rem_sh;
    logic [WORD_SIZE-1:0] rem_diff, rem_nx, quo_nx;
    logic                 rem_ge;

    always_comb begin
        op_dec = OP_NONE;
        casez (i_insn)
            16'b0001_??????_001_???: op_dec = OP_MUL;
            16'b0001_??????_011_???: op_dec = OP_DIV;
            16'b1010_??????_11_????: op_dec = OP_MOD;
            default:                 op_dec = OP_NONE;
        endcase
    end

    assign accept = (state_q == S_IDLE) && i_start && (op_dec != OP_NONE) && !i_flush;

    always_comb begin
        mul_sum  = acc_q + (b_q[0] ? a_q : '0);
        // The shifted remainder is below 2*divisor, so the low bits of the difference are exact.
        rem_sh   = {acc_q, a_q[WORD_SIZE-1]};
        rem_ge   = rem_sh >= {1'b0, b_q};
        rem_diff = rem_sh[WORD_SIZE-1:0] - b_q;
        rem_nx   = rem_ge ? rem_diff : rem_sh[WORD_SIZE-1:0];
        quo_nx   = {a_q[WORD_SIZE-2:0], rem_ge};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_RUN;
                        op_d    = op_dec;
                        a_d     = i_r1data;
                        b_d     = i_r2data;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_d = mul_sum;
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else begin
                        acc_d = rem_nx;
                        a_d   = quo_nx;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        case (op_q)
                            OP_MUL:  result_d = mul_sum;
                            OP_DIV:  result_d = (b_q == '0) ? '0 : quo_nx;
                            default: result_d = (b_q == '0) ? '0 : rem_nx;
                        endcase
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_stall  = accept || (state_q == S_RUN);
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;
endmodule

// File: tb/tb_lc4_muldiv_seq.sv
// Directed bench for lc4_muldiv_seq: latency, stall window, arithmetic, flush and reset cases.
module tb_lc4_muldiv_seq;
    localparam logic [15:0] INSN_MUL = 16'h1008;
    localparam logic [15:0] INSN_DIV = 16'h1018;
    localparam logic [15:0] INSN_MOD = 16'hA030;
    localparam logic [15:0] INSN_ADD = 16'h1040;

    logic        clk = 1'b0;
    logic        rst, i_start, i_flush;
    logic [15:0] i_insn, i_r1data, i_r2data, o_result;
    logic        o_stall, o_busy, o_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lc4_muldiv_seq #(.WORD_SIZE(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_insn(i_insn),
        .i_r1data(i_r1data), .i_r2data(i_r2data), .i_flush(i_flush),
        .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    // Drives a one-cycle start; returns at the negedge just after the accept edge.
    task automatic start_op(input logic [15:0] insn, input logic [15:0] a, input logic [15:0] b,
                            output logic stall0);
        @(negedge clk);
        i_start = 1'b1; i_insn = insn; i_r1data = a; i_r2data = b;
        #1 stall0 = o_stall;
        @(negedge clk);
        i_start = 1'b0; i_insn = 16'h0000; i_r1data = 16'hDEAD; i_r2data = 16'hBEEF;
    endtask

    // Edges after accept until o_done seen (-1 if never), plus stall count before it.
    task automatic wait_done(output int edges, output logic [15:0] res, output int stalls);
        edges = -1; stalls = 0; res = 16'hxxxx;
        for (int k = 0; k <= 40; k++) begin
            if (o_done) begin
                edges = k; res = o_result;
                break;
            end
            if (o_stall) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic watch_no_done(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_done) seen++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0;
        i_start = 1'b1; i_insn = INSN_MUL; i_r1data = 16'h0007; i_r2data = 16'h0006;
        repeat (2) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", o_done); end
        n_vec++; if (o_result !== 16'h0000) begin n_err++; $display("FAIL reset_result got=%h exp=0000", o_result); end
        i_start = 1'b0;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic s0; int e, st; logic [15:0] r;
        start_op(INSN_MUL, 16'h0007, 16'h0006, s0);
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_run got=%b exp=1", o_busy); end
        wait_done(e, r, st);
        n_vec++; if (e !== 16) begin n_err++; $display("FAIL mul_latency got=%0d exp=16", e); end
        n_vec++; if (r !== 16'h002A) begin n_err++; $display("FAIL mul_7x6 got=%h exp=002a", r); end
        n_vec++; if (st + int'(s0) !== 17) begin n_err++; $display("FAIL mul_stall_cycles got=%0d exp=17", st + int'(s0)); end
        n_vec++; if (o_stall !== 1'b0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL done_cycle_stall_busy got=%b%b exp=00", o_stall, o_busy); end
        @(negedge clk);
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b exp=0", o_done); end
        repeat (3) @(negedge clk);
        n_vec++; if (o_result !== 16'h002A) begin n_err++; $display("FAIL result_held got=%h exp=002a", o_result); end
    endtask

    task automatic test_arith();
        logic [15:0] ins [9] = '{INSN_MUL, INSN_MUL, INSN_MUL, INSN_DIV, INSN_MOD,
                                 INSN_DIV, INSN_DIV, INSN_MOD, INSN_DIV};
        logic [15:0] av  [9] = '{16'h0100, 16'hFFFF, 16'h1234, 16'd100, 16'd100,
                                 16'hFFFF, 16'h8000, 16'hFFFF, 16'd5};
        logic [15:0] bv  [9] = '{16'h0100, 16'hFFFF, 16'h0003, 16'd7, 16'd7,
                                 16'h0001, 16'h0003, 16'h0010, 16'd0};
        logic [15:0] ex  [9] = '{16'h0000, 16'h0001, 16'h369C, 16'h000E, 16'h0002,
                                 16'hFFFF, 16'h2AAA, 16'h000F, 16'h0000};
        logic s0; int e, st; logic [15:0] r;
        for (int i = 0; i < 9; i++) begin
            start_op(ins[i], av[i], bv[i], s0);
            wait_done(e, r, st);
            n_vec++; if (r !== ex[i] || e !== 16) begin
                n_err++; $display("FAIL arith_%0d got=%h/%0d exp=%h/16", i, r, e, ex[i]); end
        end
        // remainder with a zero divisor, latency checked as well
        start_op(INSN_MOD, 16'd5, 16'd0, s0);
        wait_done(e, r, st);
        n_vec++; if (r !== 16'h0000 || e !== 16) begin
            n_err++; $display("FAIL mod_by_zero got=%h/%0d exp=0000/16", r, e); end
    endtask

    task automatic test_none_insn();
        logic s0;
        start_op(INSN_ADD, 16'h0003, 16'h0004, s0);
        n_vec++; if (s0 !== 1'b0) begin n_err++; $display("FAIL add_stall got=%b exp=0", s0); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL add_busy got=%b exp=0", o_busy); end
        // flush outranks a valid start in IDLE
        @(negedge clk);
        i_start = 1'b1; i_insn = INSN_MUL; i_flush = 1'b1;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_start_stall got=%b exp=0", o_stall); end
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_back_to_back();
        logic s0; int e, st; logic [15:0] r;
        start_op(INSN_MUL, 16'h0003, 16'h0004, s0);
        repeat (5) @(negedge clk);
        i_start = 1'b1; i_insn = INSN_MUL; i_r1data = 16'h0009; i_r2data = 16'h0009;
        @(negedge clk);
        i_start = 1'b0; i_insn = 16'h0000;
        wait_done(e, r, st);
        n_vec++; if (r !== 16'h000C || e !== 10) begin
            n_err++; $display("FAIL start_in_run got=%h/%0d exp=000c/10", r, e); end
        // start offered in the DONE cycle is dropped
        i_start = 1'b1; i_insn = INSN_MUL; i_r1data = 16'h0002; i_r2data = 16'h0002;
        #1;
        n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL done_start_stall got=%b exp=0", o_stall); end
        @(negedge clk);
        i_start = 1'b0;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL done_start_busy got=%b exp=0", o_busy); end
        start_op(INSN_DIV, 16'd100, 16'd7, s0);
        wait_done(e, r, st);
        n_vec++; if (r !== 16'h000E || e !== 16) begin
            n_err++; $display("FAIL after_done_accept got=%h/%0d exp=000e/16", r, e); end
    endtask

    task automatic test_flush();
        int its [2] = '{5, 16};
        logic s0; int seen;
        for (int i = 0; i < 2; i++) begin
            start_op(INSN_MUL, 16'h0005, 16'h0005, s0);
            repeat (its[i] - 1) @(negedge clk);
            i_flush = 1'b1;
            @(negedge clk);
            i_flush = 1'b0;
            n_vec++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                n_err++; $display("FAIL flush_it%0d_state got=%b%b exp=00", its[i], o_busy, o_done); end
            n_vec++; if (o_result !== 16'h000E) begin
                n_err++; $display("FAIL flush_it%0d_result got=%h exp=000e", its[i], o_result); end
            watch_no_done(20, seen);
            n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_it%0d_nodone got=%0d exp=0", its[i], seen); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic s0; int e, st, seen; logic [15:0] r;
        start_op(INSN_MUL, 16'hFFFF, 16'hFFFF, s0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({o_busy, o_done, o_stall, o_result} !== 19'd0) begin
            n_err++; $display("FAIL rst_mid_run got=%b%b%b/%h exp=000/0000", o_busy, o_done, o_stall, o_result); end
        rst = 1'b0;
        watch_no_done(20, seen);
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_nodone got=%0d exp=0", seen); end
        start_op(INSN_MUL, 16'h0003, 16'h0005, s0);
        wait_done(e, r, st);
        n_vec++; if (r !== 16'h000F || e !== 16) begin
            n_err++; $display("FAIL rst_then_mul got=%h/%0d exp=000f/16", r, e); end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_insn = 16'h0000; i_r1data = 16'h0000; i_r2data = 16'h0000;
        test_reset();
        test_mul_basic();
        test_arith();
        test_none_insn();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
